battle_datapath: RTL and testbench

//  HP/damage datapath directly downstream of the battle control FSM.
//  - Consumes load_ai_hp, apply_ai_damage, apply_p_damage.
//  - Holds both Pokemon HP registers and computes damage = (power*atk)/(def+1).
//    The multiply is a sequential shift-add; the divide is a restoring divider.
//  - Returns p_hp/ai_hp, fainted flags and busy/done. The FSM must wait for done.

---
 rtl/battle_datapath.sv | 130 +++++++++++++
 tb/tb_battle_datapath.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/battle_datapath.sv
// HP/damage datapath behind the battle FSM: damage = (power*atk)/(def+1)
// using a shift-add multiply and a restoring divide, then a saturating HP subtract.
module battle_datapath #(
    parameter int HP_W       = 8,
    parameter int STAT_W     = 8,
    parameter int P_HP_INIT  = 100,
    parameter int AI_HP_INIT = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_ai_hp,
    input  logic              apply_ai_damage,
    input  logic              apply_p_damage,
    input  logic [HP_W-1:0]   ai_hp_init,
    input  logic [STAT_W-1:0] move_power,
    input  logic [STAT_W-1:0] p_atk,
    input  logic [STAT_W-1:0] p_def,
    input  logic [STAT_W-1:0] ai_atk,
    input  logic [STAT_W-1:0] ai_def,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   ai_hp,
    output logic              p_fainted,
    output logic              ai_fainted,
    output logic              busy,
    output logic              done
);
    localparam int PW = 2 * STAT_W;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, APPLY} state_t;
    state_t state, next;

    logic [CW-1:0]     cnt;
    logic [STAT_W-1:0] mplier;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     work;     // product during MUL, dividend/quotient during DIV
    logic [STAT_W:0]   divisor;
    logic [STAT_W:0]   rem;
    logic              tgt_ai;
    logic              start;

    logic [STAT_W+1:0] rem_sh;
    logic [STAT_W+1:0] diff;
    logic              qbit;
    logic [HP_W-1:0]   dmg;
    logic [HP_W-1:0]   tgt_hp;
    logic [HP_W-1:0]   new_hp;

    // load_ai_hp wins over both damage requests; losers are simply dropped
    assign start = (state == IDLE) && !load_ai_hp && (apply_ai_damage || apply_p_damage);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  if (start) next = MUL;
            MUL:   if (cnt == CW'(STAT_W - 1)) next = DIV;
            DIV:   if (cnt == CW'(PW - 1)) next = APPLY;
            APPLY: next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // restoring divide step: shift in the next dividend bit, subtract if no borrow
    always_comb begin
        rem_sh = {rem, work[PW-1]};
        diff   = rem_sh - {1'b0, divisor};
        qbit   = !diff[STAT_W+1];
        dmg    = (|work[PW-1:HP_W]) ? {HP_W{1'b1}} : work[HP_W-1:0];
        tgt_hp = tgt_ai ? ai_hp : p_hp;
        new_hp = (dmg >= tgt_hp) ? '0 : tgt_hp - dmg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            work    <= '0;
            divisor <= '0;
            rem     <= '0;
            tgt_ai  <= 1'b0;
            p_hp    <= HP_W'(P_HP_INIT);
            ai_hp   <= HP_W'(AI_HP_INIT);
            done    <= 1'b0;
        end else begin
            done <= (state == APPLY);
            cnt  <= (next != state) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (load_ai_hp) begin
                        ai_hp <= ai_hp_init;
                    end else if (start) begin
                        tgt_ai <= apply_ai_damage;
                        mplier <= move_power;
                        mcand  <= PW'(apply_ai_damage ? p_atk : ai_atk);
                        divisor <= {1'b0, (apply_ai_damage ? ai_def : p_def)} + 1'b1;
                        work   <= '0;
                        rem    <= '0;
                    end
                end
                MUL: begin
                    work   <= work + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
                DIV: begin
                    work <= {work[PW-2:0], qbit};
                    rem  <= qbit ? diff[STAT_W:0] : rem_sh[STAT_W:0];
                end
                APPLY: begin
                    if (tgt_ai) ai_hp <= new_hp;
                    else        p_hp  <= new_hp;
                end
                default: ;
            endcase
        end
    end

    assign p_fainted  = (p_hp == '0);
    assign ai_fainted = (ai_hp == '0);
endmodule

// File: tb/tb_battle_datapath.sv
// Directed bench for battle_datapath: latency, saturation, priority, abort on reset.
module tb_battle_datapath;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_ai_hp = 0, apply_ai_damage = 0, apply_p_damage = 0;
    logic [7:0] ai_hp_init = 0, move_power = 0, p_atk = 0, p_def = 0, ai_atk = 0, ai_def = 0;
    logic [7:0] p_hp, ai_hp;
    logic       p_fainted, ai_fainted, busy, done;

    int checks = 0, errors = 0;
    int lat, bcnt, dcnt;
    logic [7:0] mid_ai, mid_p;

    battle_datapath dut (
        .clk(clk), .reset(reset), .load_ai_hp(load_ai_hp),
        .apply_ai_damage(apply_ai_damage), .apply_p_damage(apply_p_damage),
        .ai_hp_init(ai_hp_init), .move_power(move_power),
        .p_atk(p_atk), .p_def(p_def), .ai_atk(ai_atk), .ai_def(ai_def),
        .p_hp(p_hp), .ai_hp(ai_hp), .p_fainted(p_fainted), .ai_fainted(ai_fainted),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // raise request(s) at a negedge, drop after the accept edge, wait for done
    task automatic op(input logic a, input logic p);
        apply_ai_damage = a;
        apply_p_damage  = p;
        @(posedge clk);
        @(negedge clk);
        apply_ai_damage = 0;
        apply_p_damage  = 0;
        move_power = 8'd255; p_atk = 8'd255; ai_atk = 8'd255; p_def = 8'd0; ai_def = 8'd0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (lat == 12) begin mid_ai = ai_hp; mid_p = p_hp; end
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_p_hp", p_hp, 100);
        chk("rst_ai_hp", ai_hp, 100);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 0;
        @(negedge clk);

        // 200/5 = 40 -> ai_hp 60; inputs scrambled after accept must not matter
        move_power = 20; p_atk = 10; ai_def = 4;
        op(1, 0);
        chk("t1_latency", lat, 25);
        chk("t1_busy_cycles", bcnt, 25);
        chk("t1_mid_ai", mid_ai, 100);
        chk("t1_ai_hp", ai_hp, 60);
        chk("t1_p_hp", p_hp, 100);
        chk("t1_busy_done", busy, 0);

        // 2000/10 = 200 >= 60 -> 0
        move_power = 40; p_atk = 50; ai_def = 9;
        op(1, 0);
        chk("t2_ai_hp", ai_hp, 0);
        chk("t2_ai_faint", ai_fainted, 1);
        chk("t2_p_hp", p_hp, 100);

        // load wins over a same-cycle damage request
        ai_hp_init = 150; move_power = 40; p_atk = 50; ai_def = 0;
        load_ai_hp = 1; apply_ai_damage = 1;
        @(negedge clk);
        load_ai_hp = 0; apply_ai_damage = 0;
        chk("t6_ai_hp", ai_hp, 150);
        chk("t6_ai_faint", ai_fainted, 0);
        chk("t6_busy", busy, 0);
        dcnt = 0;
        repeat (30) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("t6_no_done", dcnt, 0);
        chk("t6_ai_hold", ai_hp, 150);

        // 65025/1 clamps to 255 -> p_hp 0
        move_power = 255; ai_atk = 255; p_def = 0;
        op(0, 1);
        chk("t3_p_hp", p_hp, 0);
        chk("t3_p_faint", p_fainted, 1);
        chk("t3_mid_p", mid_p, 100);
        chk("t3_ai_hp", ai_hp, 150);

        // zero damage, then a request raised in the done cycle
        move_power = 0; p_atk = 10; ai_def = 4;
        op(1, 0);
        chk("z_latency", lat, 25);
        chk("z_ai_hp", ai_hp, 150);
        move_power = 20; p_atk = 10; ai_def = 4;
        op(1, 0);
        chk("b2b_latency", lat, 25);
        chk("b2b_ai_hp", ai_hp, 110);

        // both damage requests together, plus a pulse while busy
        reset = 1;
        @(negedge clk);
        reset = 0;
        move_power = 20; p_atk = 10; ai_def = 4; ai_atk = 30; p_def = 0;
        apply_ai_damage = 1; apply_p_damage = 1;
        @(negedge clk);
        apply_ai_damage = 0; apply_p_damage = 0;
        dcnt = 0;
        repeat (5) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        apply_p_damage = 1;
        @(negedge clk);
        apply_p_damage = 0;
        repeat (40) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("t4_done_count", dcnt, 1);
        chk("t4_ai_hp", ai_hp, 60);
        chk("t4_p_hp", p_hp, 100);

        // reset ten cycles into an operation aborts it
        move_power = 20; p_atk = 10; ai_def = 4;
        apply_ai_damage = 1;
        @(negedge clk);
        apply_ai_damage = 0;
        repeat (9) @(negedge clk);
        chk("t5_busy_pre", busy, 1);
        reset = 1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_ai_hp", ai_hp, 100);
        chk("t5_p_hp", p_hp, 100);
        @(negedge clk);
        reset = 0;
        dcnt = 0;
        repeat (40) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("t5_no_done", dcnt, 0);
        chk("t5_ai_hold", ai_hp, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
